// File: rtl/regfile_pkg.sv
// Shared RV32I definitions used by the register file and its read ports.
package rv32i_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: two read ports, one write port and the ready flag.
interface regfile_if
  import rv32i_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
);

  logic [ADDR_W-1:0] rs1_addr_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rs1_data_o;
  logic [DATA_W-1:0] rs2_data_o;
  logic [DATA_W-1:0] rd_data_i;
  logic              rd_wren_i;
  logic              ready_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, rd_addr_i, rd_data_i, rd_wren_i,
    input  rs1_data_o, rs2_data_o, ready_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, rd_addr_i, rd_data_i, rd_wren_i,
    output rs1_data_o, rs2_data_o, ready_o
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: x0 override, optional write-first bypass
// (REGFILE_BYPASS_EN), then array read.
module regfile_rd_port
  import rv32i_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              ready_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] regs_i [1:(2**ADDR_W)-1],
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] data_o
);

`ifdef REGFILE_BYPASS_EN
  // Read mux with forwarding of the in-flight write
  always_comb begin
    data_o = {DATA_W{1'b0}};
    if (addr_i == {ADDR_W{1'b0}}) begin
      data_o = {DATA_W{1'b0}};
    end else if (!ready_i) begin
      data_o = {DATA_W{1'b0}};
    end else if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end else begin
      data_o = regs_i[addr_i];
    end
  end
`else
  logic unused_wr_s;
  assign unused_wr_s = ^{wr_en_i, wr_addr_i, wr_data_i};

  // Read mux returning the stored (pre-edge) value
  always_comb begin
    data_o = {DATA_W{1'b0}};
    if (addr_i == {ADDR_W{1'b0}}) begin
      data_o = {DATA_W{1'b0}};
    end else if (!ready_i) begin
      data_o = {DATA_W{1'b0}};
    end else begin
      data_o = regs_i[addr_i];
    end
  end
`endif

endmodule

// File: rtl/regfile.sv
// 2R/1W RV32I register file with x0 hardwired to zero and a post-reset
// sequential clear engine. Optional macro REGFILE_BYPASS_EN enables write-first reads.
module regfile
  import rv32i_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic      clk_i,
  input  logic      rst_i,
  regfile_if.slave  bus
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] regs_q [1:NREGS-1];

  logic              wr_en_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              is_ready_s;

  assign is_ready_s = (state_q == RF_READY);

  // Next-state logic for the clear engine
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    case (state_q)
      RF_CLEAR: begin
        clr_idx_d = clr_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_READY;
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      RF_READY: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_idx_d = {{(ADDR_W-1){1'b0}}, 1'b1};
        ready_d   = 1'b0;
      end
    endcase
  end

  // FSM, clear counter and ready flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= {{(ADDR_W-1){1'b0}}, 1'b1};
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Single array write port shared by the clear engine and rd writeback
  always_comb begin
    wr_en_s = is_ready_s && bus.rd_wren_i && (bus.rd_addr_i != {ADDR_W{1'b0}});
    if (state_q == RF_CLEAR) begin
      we_s    = !rst_i;
      waddr_s = clr_idx_q;
      wdata_s = {DATA_W{1'b0}};
    end else begin
      we_s    = !rst_i && wr_en_s;
      waddr_s = bus.rd_addr_i;
      wdata_s = bus.rd_data_i;
    end
  end

  // Register storage; contents survive reset until the clear engine reaches them
  always_ff @(posedge clk_i) begin
    if (we_s) begin
      regs_q[waddr_s] <= wdata_s;
    end
  end

  assign bus.ready_o = ready_q;

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs1 (
    .ready_i   (is_ready_s),
    .addr_i    (bus.rs1_addr_i),
    .regs_i    (regs_q),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (bus.rd_addr_i),
    .wr_data_i (bus.rd_data_i),
    .data_o    (bus.rs1_data_o)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs2 (
    .ready_i   (is_ready_s),
    .addr_i    (bus.rs2_addr_i),
    .regs_i    (regs_q),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (bus.rd_addr_i),
    .wr_data_i (bus.rd_data_i),
    .data_o    (bus.rs2_data_o)
  );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    int          port;   // 0 = rs1_data_o, 1 = rs2_data_o, 2 = ready_o
    logic [31:0] exp;
    string       nm;
  } item_t;

  item_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // Monitor: drain every expectation queued for the current cycle
  always @(negedge clk_i) begin
    item_t       it;
    logic [31:0] act;
    while (q.size() > 0) begin
      it = q.pop_front();
      case (it.port)
        0:       act = bus.rs1_data_o;
        1:       act = bus.rs2_data_o;
        default: act = {31'd0, bus.ready_o};
      endcase
      n_vec++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h", it.nm, act, it.exp);
      end
    end
  end

  // Watchdog: abort if the test never completes
  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $finish;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_now(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (direct): got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int max_edges, input string nm);
    int waited;
    waited = 0;
    while ((bus.ready_o !== 1'b1) && (waited < max_edges)) begin
      tick();
      waited++;
    end
    n_vec++;
    if (bus.ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s: ready_o not high within %0d edges", nm, max_edges);
    end
  endtask

  task automatic expect_v(input int port, input logic [31:0] v, input string nm);
    item_t it;
    it.port = port;
    it.exp  = v;
    it.nm   = nm;
    q.push_back(it);
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.rd_wren_i = en;
    bus.rd_addr_i = a;
    bus.rd_data_i = d;
  endtask

  // Release reset and step through a full clear, checking ready_o on every edge
  task automatic run_clear(input string nm);
    rst_i = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      expect_v(2, (k == 31) ? 32'd1 : 32'd0, nm);
    end
    wait_ready(0, {nm, "_wait"});
  endtask

  task automatic check_all_zero(input string nm);
    wr(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr_i = 5'(i);
      bus.rs2_addr_i = 5'(31 - i);
      expect_v(0, 32'd0, nm);
      expect_v(1, 32'd0, nm);
      tick();
    end
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) begin
      wr(1'b1, 5'(i), 32'(i));
      tick();
    end
    wr(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    bus.rs1_addr_i = 5'd0;
    bus.rs2_addr_i = 5'd0;
    wr(1'b0, 5'd0, 32'd0);

    // Reset held for three edges
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_v(2, 32'd0, "reset_ready");
      check_now({31'd0, bus.ready_o}, 32'd0, "reset_state");
    end

    // Clear phase: reads of x5 return 0, writes to x5 are dropped
    bus.rs1_addr_i = 5'd5;
    wr(1'b1, 5'd5, 32'h0000ABCD);
    rst_i = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      expect_v(0, 32'd0, "clear_rs1_x5");
      tick();
      expect_v(2, (k == 31) ? 32'd1 : 32'd0, "clear_ready");
    end
    wait_ready(0, "clear_wait");
    wr(1'b0, 5'd0, 32'd0);
    expect_v(0, 32'd0, "x5_write_ignored");
    tick();

    // Write x7 then read it on both ports
    wr(1'b1, 5'd7, 32'hDEADBEEF);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    bus.rs1_addr_i = 5'd7;
    bus.rs2_addr_i = 5'd7;
    expect_v(0, 32'hDEADBEEF, "x7_rs1");
    expect_v(1, 32'hDEADBEEF, "x7_rs2");
    tick();

    // x0 write is discarded
    wr(1'b1, 5'd0, 32'hFFFFFFFF);
    bus.rs1_addr_i = 5'd0;
    expect_v(0, 32'd0, "x0_same_cycle");
    tick();
    wr(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      expect_v(0, 32'd0, "x0_after");
      tick();
    end

    // Same-cycle read/write hazard on x3
    wr(1'b1, 5'd3, 32'h00000011);
    tick();
    wr(1'b1, 5'd3, 32'h00000022);
    bus.rs2_addr_i = 5'd3;
`ifdef REGFILE_BYPASS_EN
    expect_v(1, 32'h00000022, "hazard_same_cycle");
`else
    expect_v(1, 32'h00000011, "hazard_same_cycle");
`endif
    tick();
    wr(1'b0, 5'd0, 32'd0);
    expect_v(1, 32'h00000022, "hazard_next_cycle");
    tick();

    // Fill with index values and read them back
    fill_index();
    for (int i = 1; i < 32; i++) begin
      bus.rs1_addr_i = 5'(i);
      bus.rs2_addr_i = 5'(32 - i);
      expect_v(0, 32'(i), "fill_rs1");
      expect_v(1, 32'(32 - i), "fill_rs2");
      tick();
    end

    // Reset in READY drops ready_o at that edge, clear wipes everything
    rst_i = 1'b1;
    tick();
    expect_v(2, 32'd0, "rst_ready_drop");
    run_clear("rst_clear_ready");
    check_all_zero("rst_all_zero");

    // Reset after 10 clear edges restarts the clear
    fill_index();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
    end
    rst_i = 1'b1;
    tick();
    expect_v(2, 32'd0, "midclear_ready_drop");
    run_clear("midclear_ready");
    check_all_zero("midclear_all_zero");

    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
